// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: status codes, register ids and instruction codes used by every pipeline stage.
package y86_pkg;

  localparam logic [3:0] SBUB = 4'd0;
  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SHLT = 4'd2;
  localparam logic [3:0] SADR = 4'd3;
  localparam logic [3:0] SINS = 4'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Any status outside HLT/ADR/INS that still halts is reported as an invalid instruction.
  function automatic logic [3:0] fault_stat(input logic [3:0] s);
    return (s == SHLT || s == SADR || s == SINS) ? s : SINS;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// 15x64 register storage with E/M write ports (M wins on same index) and three combinational reads.
// Writes land on posedge; index RNONE has no storage, so writes to it drop and reads return 0.
module regfile_bank
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_e,
  input  logic [3:0]  addr_e,
  input  logic [63:0] dat_e,
  input  logic        we_m,
  input  logic [3:0]  addr_m,
  input  logic [63:0] dat_m,
  input  logic [3:0]  raddr_a,
  output logic [63:0] rdata_a,
  input  logic [3:0]  raddr_b,
  output logic [63:0] rdata_b,
  input  logic [3:0]  raddr_c,
  output logic [63:0] rdata_c
);

  logic [63:0] regs [15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (we_e && addr_e != RNONE) regs[addr_e] <= dat_e;
      // Issued second so the M port overrides E when both target one register.
      if (we_m && addr_m != RNONE) regs[addr_m] <= dat_m;
    end
  end

  assign rdata_a = (raddr_a == RNONE) ? 64'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == RNONE) ? 64'd0 : regs[raddr_b];
  assign rdata_c = (raddr_c == RNONE) ? 64'd0 : regs[raddr_c];

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 writeback: commits W results to the register file, latches status, counts retirements.
// Reads are combinational (optional same-cycle bypass); state updates 1 cycle later; W_stall holds everything.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             W_stall,
  input  logic [3:0]       W_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  input  logic [3:0]       dbg_addr,
  output logic [63:0]      dbg_data,
  output logic [3:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  logic        commit;
  logic        commit_aok;
  logic        commit_fault;
  logic [63:0] bank_a;
  logic [63:0] bank_b;
  logic        unused_icode;

  // Register contents are already final by the time W sees icode, so it plays no role here.
  assign unused_icode = ^W_icode;

  assign commit       = !W_stall && !halted && (W_stat != SBUB);
  assign commit_aok   = commit && (W_stat == SAOK);
  assign commit_fault = commit && (W_stat != SAOK);

  regfile_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_e    (commit_aok),
    .addr_e  (W_dstE),
    .dat_e   (W_valE),
    .we_m    (commit_aok),
    .addr_m  (W_dstM),
    .dat_m   (W_valM),
    .raddr_a (d_srcA),
    .rdata_a (bank_a),
    .raddr_b (d_srcB),
    .rdata_b (bank_b),
    .raddr_c (dbg_addr),
    .rdata_c (dbg_data)
  );

  function automatic logic [63:0] read_mux(input logic [3:0] src, input logic [63:0] stored);
    logic [63:0] v;
    v = stored;
    if (BYPASS != 0 && commit_aok && src != RNONE) begin
      if (src == W_dstM)      v = W_valM;
      else if (src == W_dstE) v = W_valE;
    end
    return v;
  endfunction

  always_comb begin
    d_rvalA = read_mux(d_srcA, bank_a);
    d_rvalB = read_mux(d_srcB, bank_b);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Stat    <= SAOK;
      halted  <= 1'b0;
      retired <= '0;
    end else begin
      if (commit) retired <= retired + CNT_W'(1);
      if (commit_fault) begin
        Stat   <= fault_stat(W_stat);
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench: two instances (bypass/32-bit counter, no-bypass/4-bit counter) share stimulus; a queue-fed monitor checks at negedge.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        W_stall;
  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM, d_srcA, d_srcB, dbg_addr;
  logic [63:0] W_valE, W_valM;

  logic [63:0] a_rvalA, a_rvalB, a_dbg, b_rvalA, b_rvalB, b_dbg;
  logic [3:0]  a_stat, b_stat;
  logic        a_halted, b_halted;
  logic [31:0] a_retired;
  logic [3:0]  b_retired;

  always #5 clk = ~clk;

  writeback_regfile #(.BYPASS(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(a_rvalA), .d_rvalB(a_rvalB),
    .dbg_addr(dbg_addr), .dbg_data(a_dbg), .Stat(a_stat), .halted(a_halted), .retired(a_retired)
  );

  writeback_regfile #(.BYPASS(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .W_stall(W_stall), .W_stat(W_stat), .W_icode(W_icode),
    .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_rvalA(b_rvalA), .d_rvalB(b_rvalB),
    .dbg_addr(dbg_addr), .dbg_data(b_dbg), .Stat(b_stat), .halted(b_halted), .retired(b_retired)
  );

  localparam int A_RVALA = 0, A_RVALB = 1, A_DBG = 2, A_STAT = 3, A_HALT = 4, A_RET = 5;
  localparam int B_RVALA = 6, B_DBG = 7, B_RET = 8, B_HALT = 9;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  task automatic expect_val(input string name, input int sel, input logic [63:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    q.push_back(e);
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      A_RVALA: return a_rvalA;
      A_RVALB: return a_rvalB;
      A_DBG:   return a_dbg;
      A_STAT:  return {60'd0, a_stat};
      A_HALT:  return {63'd0, a_halted};
      A_RET:   return {32'd0, a_retired};
      B_RVALA: return b_rvalA;
      B_DBG:   return b_dbg;
      B_RET:   return {60'd0, b_retired};
      B_HALT:  return {63'd0, b_halted};
      default: return 64'hX;
    endcase
  endfunction

  // Monitor: drains every expectation queued during this cycle and compares against live outputs.
  initial begin
    exp_t e;
    logic [63:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        act = observe(e.sel);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic drive(input logic stall, input logic [3:0] stat,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] dbg);
    W_stall = stall; W_stat = stat; W_icode = 4'h6;
    W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    d_srcA = sa; d_srcB = sb; dbg_addr = dbg;
  endtask

  task automatic idle(input logic [3:0] sa, input logic [3:0] dbg);
    drive(1'b0, 4'd0, 4'hF, 64'd0, 4'hF, 64'd0, sa, 4'hF, dbg);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(4'hF, 4'd0);
    // Reset: every register reads 0 and flags are at reset values; a write during reset is dropped.
    for (int r = 0; r < 15; r++) begin
      if (r == 6) drive(1'b0, 4'd1, 4'd6, 64'h77, 4'hF, 64'd0, 4'hF, 4'hF, 4'(r));
      else idle(4'hF, 4'(r));
      expect_val($sformatf("reset_dbg_a_r%0d", r), A_DBG, 64'd0);
      expect_val($sformatf("reset_dbg_b_r%0d", r), B_DBG, 64'd0);
      tick();
    end
    idle(4'hF, 4'd6);
    expect_val("reset_stat", A_STAT, 64'd1);
    expect_val("reset_halted", A_HALT, 64'd0);
    expect_val("reset_retired", A_RET, 64'd0);
    expect_val("reset_rnone_read", A_RVALA, 64'd0);
    expect_val("reset_write_dropped", A_DBG, 64'd0);
    tick();
    rst_n = 1'b1;

    // Both ports write; bypass instance sees the new values the same cycle.
    drive(1'b0, 4'd1, 4'd2, 64'h11, 4'd3, 64'h22, 4'd2, 4'd3, 4'd2);
    expect_val("byp_rvalA", A_RVALA, 64'h11);
    expect_val("byp_rvalB", A_RVALB, 64'h22);
    expect_val("nobyp_rvalA", B_RVALA, 64'd0);
    expect_val("nobyp_dbg_pre", A_DBG, 64'd0);
    tick();
    idle(4'd2, 4'd3);
    expect_val("r2_after_a", A_RVALA, 64'h11);
    expect_val("r2_after_b", B_RVALA, 64'h11);
    expect_val("r3_dbg", A_DBG, 64'h22);
    expect_val("retired_1_a", A_RET, 64'd1);
    expect_val("retired_1_b", B_RET, 64'd1);
    tick();

    // Same destination on both ports: M wins, both for bypass and storage.
    drive(1'b0, 4'd1, 4'd4, 64'h100, 4'd4, 64'h200, 4'd4, 4'hF, 4'd4);
    expect_val("same_dst_bypass", A_RVALA, 64'h200);
    expect_val("same_dst_nobyp", B_RVALA, 64'd0);
    tick();
    idle(4'hF, 4'd4);
    expect_val("same_dst_r4", A_DBG, 64'h200);
    expect_val("same_dst_r4_b", B_DBG, 64'h200);
    expect_val("retired_2", A_RET, 64'd2);
    tick();

    // Stall and bubble commit nothing, including a stalled HLT.
    drive(1'b1, 4'd1, 4'd5, 64'd7, 4'hF, 64'd0, 4'd5, 4'hF, 4'd5);
    expect_val("stall_no_bypass", A_RVALA, 64'd0);
    tick();
    drive(1'b0, 4'd0, 4'd5, 64'd7, 4'hF, 64'd0, 4'hF, 4'hF, 4'd5);
    expect_val("stall_r5", A_DBG, 64'd0);
    expect_val("stall_retired", A_RET, 64'd2);
    tick();
    drive(1'b1, 4'd2, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF, 4'd5);
    expect_val("bubble_r5", A_DBG, 64'd0);
    expect_val("bubble_retired", A_RET, 64'd2);
    tick();
    idle(4'hF, 4'd5);
    expect_val("stalled_hlt_stat", A_STAT, 64'd1);
    expect_val("stalled_hlt_halted", A_HALT, 64'd0);
    expect_val("stalled_hlt_retired", A_RET, 64'd2);
    tick();

    // 4-bit counter on the second instance wraps 15 -> 0.
    for (int i = 0; i < 13; i++) begin
      drive(1'b0, 4'd1, 4'hF, 64'd1, 4'hF, 64'd2, 4'hF, 4'hF, 4'd0);
      tick();
    end
    idle(4'hF, 4'd0);
    expect_val("count_15_b", B_RET, 64'd15);
    expect_val("count_15_a", A_RET, 64'd15);
    expect_val("rnone_write_dropped", A_DBG, 64'd0);
    drive(1'b0, 4'd1, 4'hF, 64'd1, 4'hF, 64'd2, 4'hF, 4'hF, 4'd0);
    tick();
    idle(4'hF, 4'd0);
    expect_val("count_wrap_b", B_RET, 64'd0);
    expect_val("count_16_a", A_RET, 64'd16);
    tick();

    // Exception: ADR retires without writing, then everything freezes.
    drive(1'b0, 4'd1, 4'd1, 64'd9, 4'hF, 64'd0, 4'hF, 4'hF, 4'd1);
    tick();
    drive(1'b0, 4'd3, 4'd1, 64'hDEAD, 4'hF, 64'd0, 4'd1, 4'hF, 4'd1);
    expect_val("fault_no_bypass", A_RVALA, 64'd9);
    tick();
    idle(4'hF, 4'd1);
    expect_val("fault_r1", A_DBG, 64'd9);
    expect_val("fault_stat", A_STAT, 64'd3);
    expect_val("fault_halted", A_HALT, 64'd1);
    expect_val("fault_halted_b", B_HALT, 64'd1);
    expect_val("fault_retired", A_RET, 64'd18);
    tick();
    drive(1'b0, 4'd1, 4'd1, 64'h55, 4'hF, 64'd0, 4'd1, 4'hF, 4'd1);
    expect_val("halted_no_bypass", A_RVALA, 64'd9);
    tick();
    drive(1'b0, 4'd2, 4'hF, 64'd0, 4'hF, 64'd0, 4'hF, 4'hF, 4'd1);
    expect_val("halted_r1", A_DBG, 64'd9);
    expect_val("halted_retired", A_RET, 64'd18);
    tick();
    idle(4'hF, 4'd2);
    expect_val("frozen_stat", A_STAT, 64'd3);
    expect_val("frozen_retired", A_RET, 64'd18);
    tick();

    // Async reset between edges clears state before the next posedge.
    rst_n = 1'b0;
    idle(4'hF, 4'd1);
    expect_val("async_r1_a", A_DBG, 64'd0);
    expect_val("async_r1_b", B_DBG, 64'd0);
    expect_val("async_stat", A_STAT, 64'd1);
    expect_val("async_halted", A_HALT, 64'd0);
    expect_val("async_retired", A_RET, 64'd0);
    tick();
    rst_n = 1'b1;

    // Unknown status code halts as INS.
    drive(1'b0, 4'd7, 4'd2, 64'h33, 4'hF, 64'd0, 4'hF, 4'hF, 4'd2);
    tick();
    idle(4'hF, 4'd2);
    expect_val("unk_stat", A_STAT, 64'd4);
    expect_val("unk_halted", A_HALT, 64'd1);
    expect_val("unk_retired", A_RET, 64'd1);
    expect_val("unk_no_write", A_DBG, 64'd0);
    tick();

    tick();
    tick();
    stim_done = 1'b1;
  end

  initial begin
    fork
      wait (stim_done);
      #20000;
    join_any
    disable fork;
    if (!stim_done) begin
      errors++;
      $display("FAIL timeout: got unfinished stimulus, expected completion");
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
